// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle controller for the P4 datapath.
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. The write
// strobes and the datapath mux selects are combinational from the state
// and the instruction word.
//
// Optional build macro: CTRL_INSTR_CNT_EN
//   Defined   : instr_cnt counts PCWrite pulses and wraps at 2^CNT_W.
//   Undefined : instr_cnt is tied to 0 and no counter flops are built.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   instr      in   [31:0] instruction word from IR
//   zero       in   ALU zero flag (beq is resolved in NPC, not here)
//   PCWrite    out  PC load strobe
//   IRWrite    out  IR load strobe
//   NPCOp      out  [1:0] 00 PC+4, 01 beq, 10 j/jal, 11 jr
//   RegWrite   out  GRF write enable
//   EXTOp      out  [1:0] 00 zero-ext, 01 sign-ext, 10 lui
//   ALUOp      out  [3:0] 0000 add, 0001 sub, 0010 or
//   MemWrite   out  DM write enable
//   RegA3Sel   out  [1:0] 00 rd, 01 rt, 10 $31
//   RegDataSel out  [1:0] 00 ALU, 01 DM, 10 Ext, 11 PC4
//   AluBSel    out  [1:0] 00 RD2, 01 Ext
//   state      out  [2:0] current state code
//   instr_cnt  out  [CNT_W-1:0] retired-instruction count
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic [1:0]       NPCOp,
    output logic             RegWrite,
    output logic [1:0]       EXTOp,
    output logic [3:0]       ALUOp,
    output logic             MemWrite,
    output logic [1:0]       RegA3Sel,
    output logic [1:0]       RegDataSel,
    output logic [1:0]       AluBSel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Branch resolution lives in NPC; only the opcode/funct fields matter here.
    logic unused_bits;
    assign unused_bits = ^{zero, instr[25:6]};

    // ---------------- instruction decode ----------------
    logic [5:0] op, funct;
    logic       is_rtype, is_addu, is_subu, is_jr;
    logic       is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
    logic       is_short;   // finishes in DECODE

    assign op       = instr[31:26];
    assign funct    = instr[5:0];
    assign is_rtype = (op == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_jr    = is_rtype && (funct == 6'b001000);
    assign is_ori   = (op == 6'b001101);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_beq   = (op == 6'b000100);
    assign is_lui   = (op == 6'b001111);
    assign is_j     = (op == 6'b000010);
    assign is_jal   = (op == 6'b000011);
    // Anything outside the long-op set (ILLEGAL included) retires in DECODE.
    assign is_short = !(is_addu || is_subu || is_ori || is_lw || is_sw || is_beq);

    // Per-instruction select values; held unchanged across all post-FETCH
    // states so the datapath sees stable muxes for the whole instruction.
    logic [1:0] dec_npc, dec_ext, dec_a3, dec_ds, dec_bs;
    logic [3:0] dec_alu;

    always_comb begin
        dec_npc = 2'b00;
        dec_ext = 2'b00;
        dec_alu = 4'b0000;
        dec_a3  = 2'b00;
        dec_ds  = 2'b00;
        dec_bs  = 2'b00;
        if (is_subu) begin
            dec_alu = 4'b0001;
        end else if (is_ori) begin
            dec_alu = 4'b0010;
            dec_bs  = 2'b01;
            dec_a3  = 2'b01;
        end else if (is_lw) begin
            dec_ext = 2'b01;
            dec_bs  = 2'b01;
            dec_a3  = 2'b01;
            dec_ds  = 2'b01;
        end else if (is_sw) begin
            dec_ext = 2'b01;
            dec_bs  = 2'b01;
        end else if (is_beq) begin
            dec_alu = 4'b0001;
            dec_npc = 2'b01;
        end else if (is_lui) begin
            dec_ext = 2'b10;
            dec_a3  = 2'b01;
            dec_ds  = 2'b10;
        end else if (is_j) begin
            dec_npc = 2'b10;
        end else if (is_jal) begin
            dec_npc = 2'b10;
            dec_a3  = 2'b10;
            dec_ds  = 2'b11;
        end else if (is_jr) begin
            dec_npc = 2'b11;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // ---------------- next state / outputs ----------------
    logic pcw, irw, rgw, mmw, sel_en;

    always_comb begin
        state_d = S_FETCH;
        pcw     = 1'b0;
        irw     = 1'b0;
        rgw     = 1'b0;
        mmw     = 1'b0;
        sel_en  = 1'b0;
        case (state_q)
            S_FETCH: begin
                irw     = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                sel_en = 1'b1;
                if (is_short) begin
                    pcw = 1'b1;
                    rgw = is_jal || is_lui;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                sel_en = 1'b1;
                if (is_beq)              pcw     = 1'b1;
                else if (is_lw || is_sw) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_MEM: begin
                sel_en = 1'b1;
                if (is_sw) begin
                    mmw = 1'b1;
                    pcw = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                sel_en = 1'b1;
                rgw    = 1'b1;
                pcw    = 1'b1;
            end
            default: state_d = S_FETCH;   // codes 5-7: recover, strobes stay 0
        endcase
    end

    // Reset gating is combinational so strobes drop in the same cycle the
    // reset is asserted, not at the next edge.
    assign PCWrite    = reset & pcw;
    assign IRWrite    = reset & irw;
    assign RegWrite   = reset & rgw;
    assign MemWrite   = reset & mmw;
    assign NPCOp      = (reset && sel_en) ? dec_npc : 2'b00;
    assign EXTOp      = (reset && sel_en) ? dec_ext : 2'b00;
    assign ALUOp      = (reset && sel_en) ? dec_alu : 4'b0000;
    assign RegA3Sel   = (reset && sel_en) ? dec_a3  : 2'b00;
    assign RegDataSel = (reset && sel_en) ? dec_ds  : 2'b00;
    assign AluBSel    = (reset && sel_en) ? dec_bs  : 2'b00;
    assign state      = state_q;

    // ---------------- retired-instruction counter ----------------
`ifdef CTRL_INSTR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt_q <= '0;
        else if (PCWrite) cnt_q <= cnt_q + 1'b1;
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instr;
    logic             zero;
    logic             PCWrite, IRWrite, RegWrite, MemWrite;
    logic [1:0]       NPCOp, EXTOp, RegA3Sel, RegDataSel, AluBSel;
    logic [3:0]       ALUOp;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .NPCOp(NPCOp),
        .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUOp(ALUOp),
        .MemWrite(MemWrite), .RegA3Sel(RegA3Sel), .RegDataSel(RegDataSel),
        .AluBSel(AluBSel), .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // state, {PCWrite,IRWrite,RegWrite,MemWrite}, NPCOp, EXTOp, ALUOp, A3, Data, BSel
    typedef struct packed {
        logic [2:0] st;
        logic [3:0] strb;
        logic [1:0] npc;
        logic [1:0] ext;
        logic [3:0] alu;
        logic [1:0] a3;
        logic [1:0] ds;
        logic [1:0] bs;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] s_npc, s_ext, s_a3, s_ds, s_bs;
    logic [3:0] s_alu;

    // Selects expected for the instruction under test (post-FETCH states).
    task automatic sel(input logic [1:0] npc, input logic [1:0] ext, input logic [3:0] alu,
                       input logic [1:0] a3, input logic [1:0] ds, input logic [1:0] bs);
        s_npc = npc; s_ext = ext; s_alu = alu; s_a3 = a3; s_ds = ds; s_bs = bs;
    endtask

    // FETCH and reset cycles show all selects at 0.
    task automatic exp(input logic [2:0] st, input logic [3:0] strb, input bit zsel);
        exp_t e;
        e.st = st; e.strb = strb;
        if (zsel) begin
            e.npc = 2'b00; e.ext = 2'b00; e.alu = 4'b0000; e.a3 = 2'b00; e.ds = 2'b00; e.bs = 2'b00;
        end else begin
            e.npc = s_npc; e.ext = s_ext; e.alu = s_alu; e.a3 = s_a3; e.ds = s_ds; e.bs = s_bs;
        end
        q.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e, o;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e = q.pop_front();
        o = '{state, {PCWrite, IRWrite, RegWrite, MemWrite}, NPCOp, EXTOp, ALUOp,
              RegA3Sel, RegDataSel, AluBSel};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Compare at the falling edge, then advance past the next rising edge.
    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_pop(tag);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_cnt(input string tag, input int n);
        logic [CNT_W-1:0] e;
`ifdef CTRL_INSTR_CNT_EN
        e = CNT_W'(n);
`else
        e = '0;
        if (n < 0) e = '1;
`endif
        checks++;
        assert (instr_cnt === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, instr_cnt, e);
        end
    endtask

    initial begin
        reset = 1'b0;
        instr = 32'h0;
        zero  = 1'b0;
        sel(0, 0, 0, 0, 0, 0);

        // reset held for 2 cycles: FETCH, every strobe 0
        exp(3'd0, 4'b0000, 1); exp(3'd0, 4'b0000, 1);
        drain("reset", 2);
        check_cnt("cnt_reset", 0);
        reset = 1'b1;

        // addu $3,$1,$2 : F D E W
        instr = 32'h00221821;
        sel(2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
        exp(0, 4'b0100, 1); exp(1, 4'b0000, 0); exp(2, 4'b0000, 0); exp(4, 4'b1010, 0);
        drain("addu", 4);

        // lw $5,8($0) : F D E M W
        instr = 32'h8C050008;
        sel(2'b00, 2'b01, 4'b0000, 2'b01, 2'b01, 2'b01);
        exp(0, 4'b0100, 1); exp(1, 4'b0000, 0); exp(2, 4'b0000, 0);
        exp(3, 4'b0000, 0); exp(4, 4'b1010, 0);
        drain("lw", 5);

        // sw $5,12($0) : F D E M(MemWrite)
        instr = 32'hAC05000C;
        sel(2'b00, 2'b01, 4'b0000, 2'b00, 2'b00, 2'b01);
        exp(0, 4'b0100, 1); exp(1, 4'b0000, 0); exp(2, 4'b0000, 0); exp(3, 4'b1001, 0);
        drain("sw", 4);

        // beq taken and not taken: identical control, 3 cycles
        instr = 32'h10220003;
        sel(2'b01, 2'b00, 4'b0001, 2'b00, 2'b00, 2'b00);
        zero = 1'b1;
        exp(0, 4'b0100, 1); exp(1, 4'b0000, 0); exp(2, 4'b1000, 0);
        drain("beq_z1", 3);
        zero = 1'b0;
        exp(0, 4'b0100, 1); exp(1, 4'b0000, 0); exp(2, 4'b1000, 0);
        drain("beq_z0", 3);

        // jal : F D(link write)
        instr = 32'h0C000C00;
        sel(2'b10, 2'b00, 4'b0000, 2'b10, 2'b11, 2'b00);
        exp(0, 4'b0100, 1); exp(1, 4'b1010, 0);
        drain("jal", 2);
        check_cnt("cnt_six", 6);

        // illegal opcode retires as nop
        instr = 32'hFC000000;
        sel(0, 0, 0, 0, 0, 0);
        exp(0, 4'b0100, 1); exp(1, 4'b1000, 0);
        drain("illegal", 2);

        // lui $5,0x1234
        instr = 32'h3C051234;
        sel(2'b00, 2'b10, 4'b0000, 2'b01, 2'b10, 2'b00);
        exp(0, 4'b0100, 1); exp(1, 4'b1010, 0);
        drain("lui", 2);

        // ori $5,$5,1
        instr = 32'h34A50001;
        sel(2'b00, 2'b00, 4'b0010, 2'b01, 2'b00, 2'b01);
        exp(0, 4'b0100, 1); exp(1, 4'b0000, 0); exp(2, 4'b0000, 0); exp(4, 4'b1010, 0);
        drain("ori", 4);

        // subu $3,$1,$2
        instr = 32'h00221823;
        sel(2'b00, 2'b00, 4'b0001, 2'b00, 2'b00, 2'b00);
        exp(0, 4'b0100, 1); exp(1, 4'b0000, 0); exp(2, 4'b0000, 0); exp(4, 4'b1010, 0);
        drain("subu", 4);

        // j and jr
        instr = 32'h08000000;
        sel(2'b10, 0, 0, 0, 0, 0);
        exp(0, 4'b0100, 1); exp(1, 4'b1000, 0);
        drain("j", 2);
        instr = 32'h03E00008;
        sel(2'b11, 0, 0, 0, 0, 0);
        exp(0, 4'b0100, 1); exp(1, 4'b1000, 0);
        drain("jr", 2);
        check_cnt("cnt_twelve", 12);

        // lw interrupted by reset in MEM
        instr = 32'h8C050008;
        sel(2'b00, 2'b01, 4'b0000, 2'b01, 2'b01, 2'b01);
        exp(0, 4'b0100, 1); exp(1, 4'b0000, 0); exp(2, 4'b0000, 0);
        drain("lw_rst", 3);
        @(negedge clk);
        exp(3, 4'b0000, 0);
        check_pop("lw_rst_mem");
        reset = 1'b0;
        #1;
        exp(0, 4'b0000, 1);
        check_pop("rst_async");
        check_cnt("cnt_rst_async", 0);
        @(posedge clk);
        #1;
        exp(0, 4'b0000, 1);
        check_pop("rst_hold");
        reset = 1'b1;
        exp(0, 4'b0100, 1);
        drain("rst_release", 1);
        check_cnt("cnt_after_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
